// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the 16-bit Fibonacci LFSR run controller:
//   LFSR_WIDTH        - shift register width (16)
//   LFSR_TAPS         - polynomial mask x^16+x^14+x^13+x^11+1 (bit k <-> x^(k+1))
//   LFSR_RESET_STATE  - non-zero state held after reset
//   run_state_e       - controller FSM encoding
//   lfsr_step()       - one right-shift step of the Fibonacci register
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS        = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] LFSR_RESET_STATE = 16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_e;

  // The register shifts right and emits bit 0, so polynomial term x^(k+1)
  // (mask bit k) maps onto register bit WIDTH-1-k. For 16'hB400 this XORs
  // bits 0, 2, 3 and 5 into the new MSB.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      if (LFSR_TAPS[LFSR_WIDTH-1-i]) begin
        fb = fb ^ cur[i];
      end
    end
    return {fb, cur[LFSR_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16_core.sv
// ---------------------------------------------------------------------------
// lfsr16_core
// 16-bit Fibonacci LFSR datapath.
//   clk     in   rising-edge clock
//   reset   in   synchronous active-low reset (state -> 16'h0001, bit_out -> 0)
//   load    in   load seed into the register (has priority over step)
//   seed    in   value loaded on load
//   step    in   advance the register by one bit
//   state   out  current register contents
//   bit_out out  registered copy of state[0] after each load/step
// ---------------------------------------------------------------------------
module lfsr16_core
  import lfsr_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  step,
  output logic [LFSR_WIDTH-1:0] state,
  output logic                  bit_out
);

  logic [LFSR_WIDTH-1:0] state_reg;
  logic [LFSR_WIDTH-1:0] state_next;
  logic                  bit_out_reg;

  assign state_next = lfsr_step(state_reg);

  // bit_out is its own flop rather than state[0] so that it can read 0 out
  // of reset while the register itself holds the non-zero reset state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= LFSR_RESET_STATE;
      bit_out_reg <= 1'b0;
    end else if (load) begin
      state_reg   <= seed;
      bit_out_reg <= seed[0];
    end else if (step) begin
      state_reg   <= state_next;
      bit_out_reg <= state_next[0];
    end
  end

  assign state   = state_reg;
  assign bit_out = bit_out_reg;

endmodule

// File: rtl/lfsr_run_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_run_ctrl
// Bounded-run controller around lfsr16_core: seeds the LFSR on start, emits
// run_len bits with a valid strobe, counts ones/zeroes, flags each return to
// the seed and finishes with a done pulse.
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   start      in   run request (IDLE only)
//   abort      in   early termination (LOAD/RUN only)
//   seed       in   initial LFSR state, captured on accepted start
//   run_len    in   number of bits to emit, captured on accepted start
//   busy       out  high in LOAD and RUN
//   bit_out    out  current LFSR output bit
//   bit_valid  out  bit_out is a fresh sequence bit
//   max_tick   out  pulse: the state after this bit equals the seed
//   num_ones   out  ones emitted this run (saturating)
//   num_zeroes out  zeroes emitted this run (saturating)
//   done       out  pulse: run finished, statistics final
//   aborted    out  run ended by abort; held until the next LOAD
//   err_seed   out  pulse: start rejected because seed == 0
// ---------------------------------------------------------------------------
module lfsr_run_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] run_len,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             max_tick,
  output logic [CNT_W-1:0] num_ones,
  output logic [CNT_W-1:0] num_zeroes,
  output logic             done,
  output logic             aborted,
  output logic             err_seed
);

  run_state_e state_reg, state_next;

  logic [WIDTH-1:0] seed_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [CNT_W-1:0] ones_reg;
  logic [CNT_W-1:0] zeroes_reg;

  logic busy_reg, bit_valid_reg, max_tick_reg, done_reg, aborted_reg, err_seed_reg;
  logic max_tick_next, aborted_next, err_seed_next;

  logic             accept;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] core_state;
  logic             core_bit;
  logic             last_bit;
  logic [WIDTH-1:0] first_step;
  logic [WIDTH-1:0] second_step;

  lfsr16_core u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .seed    (seed_reg),
    .step    (core_step),
    .state   (core_state),
    .bit_out (core_bit)
  );

  // bit_cnt_reg counts bits already completed, so the bit on display is the
  // last one when one more would reach the programmed length.
  assign last_bit = ((bit_cnt_reg + CNT_W'(1)) == len_reg);

  // max_tick is registered and must line up with the bit whose successor
  // state equals the seed. The bit shown next cycle will be core_state's
  // successor, so its successor is two steps ahead of core_state. The first
  // bit of a run is shown from the seed itself, hence one step of the seed.
  assign first_step  = lfsr_step(seed_reg);
  assign second_step = lfsr_step(lfsr_step(core_state));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    core_load     = 1'b0;
    core_step     = 1'b0;
    err_seed_next = 1'b0;
    max_tick_next = 1'b0;
    aborted_next  = aborted_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (seed == '0) begin
            err_seed_next = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        core_load    = 1'b1;
        aborted_next = abort;
        if (abort || (len_reg == '0)) begin
          state_next = DONE;
        end else begin
          state_next    = RUN;
          max_tick_next = (first_step == seed_reg);
        end
      end
      RUN: begin
        core_step = 1'b1;
        // Completion wins over a coincident abort.
        if (last_bit) begin
          state_next = DONE;
        end else if (abort) begin
          state_next   = DONE;
          aborted_next = 1'b1;
        end else begin
          max_tick_next = (second_step == seed_reg);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Run parameters and statistics. Counts are cleared in LOAD and then hold
  // through DONE and IDLE until the next run loads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seed_reg    <= '0;
      len_reg     <= '0;
      bit_cnt_reg <= '0;
      ones_reg    <= '0;
      zeroes_reg  <= '0;
    end else begin
      if (accept) begin
        seed_reg <= seed;
        len_reg  <= run_len;
      end
      if (state_reg == LOAD) begin
        bit_cnt_reg <= '0;
        ones_reg    <= '0;
        zeroes_reg  <= '0;
      end else if (state_reg == RUN) begin
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        if (core_bit) begin
          if (ones_reg != '1) begin
            ones_reg <= ones_reg + CNT_W'(1);
          end
        end else begin
          if (zeroes_reg != '1) begin
            zeroes_reg <= zeroes_reg + CNT_W'(1);
          end
        end
      end
    end
  end

  // Status flags are decoded from the next state so they are registered and
  // aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_reg      <= 1'b0;
      bit_valid_reg <= 1'b0;
      max_tick_reg  <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
      err_seed_reg  <= 1'b0;
    end else begin
      busy_reg      <= (state_next == LOAD) || (state_next == RUN);
      bit_valid_reg <= (state_next == RUN);
      max_tick_reg  <= max_tick_next;
      done_reg      <= (state_next == DONE);
      aborted_reg   <= aborted_next;
      err_seed_reg  <= err_seed_next;
    end
  end

  assign busy       = busy_reg;
  assign bit_out    = core_bit;
  assign bit_valid  = bit_valid_reg;
  assign max_tick   = max_tick_reg;
  assign num_ones   = ones_reg;
  assign num_zeroes = zeroes_reg;
  assign done       = done_reg;
  assign aborted    = aborted_reg;
  assign err_seed   = err_seed_reg;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_run_ctrl
// Directed scenarios for lfsr_run_ctrl. A Fibonacci LFSR that shifts right
// emits its seed bits LSB first for the first 16 bits, so short runs from
// 16'hACE1 have expected bits and counts readable straight off the seed.
// ---------------------------------------------------------------------------
module tb_lfsr_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] seed;
  logic [15:0] run_len;
  logic        busy, bit_out, bit_valid, max_tick, done, aborted, err_seed;
  logic [15:0] num_ones, num_zeroes;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] SEED_A = 16'hACE1;

  lfsr_run_ctrl #(.WIDTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .run_len    (run_len),
    .busy       (busy),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .max_tick   (max_tick),
    .num_ones   (num_ones),
    .num_zeroes (num_zeroes),
    .done       (done),
    .aborted    (aborted),
    .err_seed   (err_seed)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents a start for one edge; returns in cycle 1 (LOAD if accepted).
  task automatic do_start(input logic [15:0] s, input logic [15:0] l);
    seed    = s;
    run_len = l;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, bit_out, bit_valid, max_tick, done, aborted, err_seed} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 0000000", {busy, bit_out, bit_valid, max_tick, done, aborted, err_seed});
    end
    n_cmp++;
    if ({num_ones, num_zeroes} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_counts: got ones=%0d zeroes=%0d required 0/0", num_ones, num_zeroes);
    end
    $display("reset: flags and counts checked");
  endtask

  task automatic test_short_run();
    do_start(SEED_A, 16'd2);
    n_cmp++;
    if ({busy, bit_valid, done} !== 3'b100) begin
      n_bad++;
      $display("FAIL short_load: got busy/valid/done=%b required 100", {busy, bit_valid, done});
    end
    tick();
    n_cmp++;
    if ({bit_valid, bit_out} !== 2'b11) begin
      n_bad++;
      $display("FAIL short_bit1: got valid/bit=%b required 11", {bit_valid, bit_out});
    end
    tick();
    n_cmp++;
    if ({bit_valid, bit_out, done} !== 3'b100) begin
      n_bad++;
      $display("FAIL short_bit2: got valid/bit/done=%b required 100", {bit_valid, bit_out, done});
    end
    tick();
    n_cmp++;
    if ({done, aborted, busy, bit_valid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL short_done_c4: got done/aborted/busy/valid=%b required 1000", {done, aborted, busy, bit_valid});
    end
    n_cmp++;
    if (num_ones !== 16'd1 || num_zeroes !== 16'd1) begin
      n_bad++;
      $display("FAIL short_counts: got ones=%0d zeroes=%0d required 1/1", num_ones, num_zeroes);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL short_done_pulse: got done=%b in cycle 5 required 0", done);
    end
    $display("short_run: seed=%h len=2 ones=%0d zeroes=%0d", SEED_A, num_ones, num_zeroes);
  endtask

  task automatic test_zero_seed();
    do_start(16'h0000, 16'd5);
    n_cmp++;
    if ({err_seed, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL zero_seed_err: got err_seed/busy=%b required 10", {err_seed, busy});
    end
    tick();
    n_cmp++;
    if ({err_seed, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL zero_seed_pulse: got err_seed/busy=%b required 00", {err_seed, busy});
    end
    n_cmp++;
    if (num_ones !== 16'd1 || num_zeroes !== 16'd1) begin
      n_bad++;
      $display("FAIL zero_seed_counts: got ones=%0d zeroes=%0d required 1/1 (unchanged)", num_ones, num_zeroes);
    end
    $display("zero_seed: err_seed pulse and held counts checked");
  endtask

  task automatic test_zero_len();
    logic seen_valid;
    do_start(16'h0001, 16'd0);
    seen_valid = bit_valid;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_len_load: got busy=%b required 1", busy);
    end
    tick();
    seen_valid = seen_valid | bit_valid;
    n_cmp++;
    if ({done, aborted, seen_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL zero_len_done: got done/aborted/seen_valid=%b required 100", {done, aborted, seen_valid});
    end
    n_cmp++;
    if (num_ones !== 16'd0 || num_zeroes !== 16'd0) begin
      n_bad++;
      $display("FAIL zero_len_counts: got ones=%0d zeroes=%0d required 0/0", num_ones, num_zeroes);
    end
    tick();
    $display("zero_len: done at cycle 2 with empty statistics");
  endtask

  // Raises abort during the abort_bit-th valid bit and checks the outcome.
  task automatic test_abort(input int abort_bit, input logic exp_aborted, input int exp_total,
                            input int exp_done_cyc, input logic chk_ones, input int exp_ones);
    int          nb;
    int          done_cyc;
    logic [15:0] got;
    logic [15:0] mask;
    nb       = 0;
    done_cyc = 0;
    got      = '0;
    mask     = (exp_total >= 16) ? 16'hFFFF : 16'((32'd1 << exp_total) - 1);
    do_start(SEED_A, 16'd100);
    for (int c = 1; c <= 300; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (bit_valid) begin
        if (nb < 16) got[nb] = bit_out;
        nb++;
        if (nb == abort_bit) abort = 1'b1;
      end
      tick();
      abort = 1'b0;
    end
    n_cmp++;
    if (done_cyc !== exp_done_cyc) begin
      n_bad++;
      $display("FAIL abort%0d_done_cycle: got %0d required %0d", abort_bit, done_cyc, exp_done_cyc);
    end
    n_cmp++;
    if (aborted !== exp_aborted) begin
      n_bad++;
      $display("FAIL abort%0d_flag: got aborted=%b required %b", abort_bit, aborted, exp_aborted);
    end
    n_cmp++;
    if (32'(num_ones) + 32'(num_zeroes) !== exp_total) begin
      n_bad++;
      $display("FAIL abort%0d_total: got %0d required %0d", abort_bit, 32'(num_ones) + 32'(num_zeroes), exp_total);
    end
    n_cmp++;
    if ((got & mask) !== (SEED_A & mask)) begin
      n_bad++;
      $display("FAIL abort%0d_bits: got %h required %h", abort_bit, got & mask, SEED_A & mask);
    end
    if (chk_ones) begin
      n_cmp++;
      if (32'(num_ones) !== exp_ones) begin
        n_bad++;
        $display("FAIL abort%0d_ones: got %0d required %0d", abort_bit, num_ones, exp_ones);
      end
    end
    tick();
    $display("abort_at_%0d: done_cycle=%0d aborted=%b total=%0d", abort_bit, done_cyc, aborted, nb);
  endtask

  task automatic test_abort_in_load();
    do_start(SEED_A, 16'd100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({done, aborted, bit_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL load_abort_done: got done/aborted/valid=%b required 110", {done, aborted, bit_valid});
    end
    n_cmp++;
    if (num_ones !== 16'd0 || num_zeroes !== 16'd0) begin
      n_bad++;
      $display("FAIL load_abort_counts: got ones=%0d zeroes=%0d required 0/0", num_ones, num_zeroes);
    end
    tick();
    $display("abort_in_load: done at cycle 2 with aborted set");
  endtask

  // start held high throughout: the request in DONE must be dropped, so the
  // second run is accepted only from IDLE in cycle 6 and loads in cycle 7.
  task automatic test_back_to_back();
    seed    = SEED_A;
    run_len = 16'd3;
    start   = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    n_cmp++;
    if ({done, busy, aborted} !== 3'b100) begin
      n_bad++;
      $display("FAIL b2b_first_done: got done/busy/aborted=%b required 100", {done, busy, aborted});
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_idle_gap: got done/busy=%b in cycle 6 required 00", {done, busy});
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_load: got busy=%b in cycle 7 required 1", busy);
    end
    for (int c = 8; c <= 11; c++) tick();
    n_cmp++;
    if (done !== 1'b1 || num_ones !== 16'd1 || num_zeroes !== 16'd2) begin
      n_bad++;
      $display("FAIL b2b_second_done: got done=%b ones=%0d zeroes=%0d required 1/1/2", done, num_ones, num_zeroes);
    end
    tick();
    $display("back_to_back: start in DONE ignored, second run done at cycle 11");
  endtask

  task automatic test_reset_mid_run();
    int          nb;
    int          done_cyc;
    logic        seen;
    logic [15:0] got;
    nb = 0;
    do_start(SEED_A, 16'd100);
    for (int c = 1; c <= 60; c++) begin
      if (bit_valid) nb++;
      if (nb == 50) break;
      tick();
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({busy, bit_out, bit_valid, max_tick, done, aborted, err_seed} !== 7'b0) begin
      n_bad++;
      $display("FAIL midrst_flags: got %b required 0000000 (bits seen before reset %0d)", {busy, bit_out, bit_valid, max_tick, done, aborted, err_seed}, nb);
    end
    n_cmp++;
    if ({num_ones, num_zeroes} !== 32'h0) begin
      n_bad++;
      $display("FAIL midrst_counts: got ones=%0d zeroes=%0d required 0/0", num_ones, num_zeroes);
    end
    reset = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen = seen | done | busy;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_quiet: got done/busy activity=%b after reset required 0", seen);
    end
    nb       = 0;
    done_cyc = 0;
    got      = '0;
    do_start(SEED_A, 16'd16);
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (bit_valid) begin
        if (nb < 16) got[nb] = bit_out;
        nb++;
      end
      tick();
    end
    n_cmp++;
    if (got !== SEED_A || done_cyc !== 18) begin
      n_bad++;
      $display("FAIL midrst_rerun: got bits=%h done_cycle=%0d required %h/18", got, done_cyc, SEED_A);
    end
    n_cmp++;
    if (num_ones !== 16'd8 || num_zeroes !== 16'd8) begin
      n_bad++;
      $display("FAIL midrst_rerun_counts: got ones=%0d zeroes=%0d required 8/8", num_ones, num_zeroes);
    end
    tick();
    $display("reset_mid_run: cleared, fresh run reproduced %h", got);
  endtask

  task automatic test_full_period();
    int nb;
    int ticks;
    int tick_bit;
    int done_cyc;
    nb       = 0;
    ticks    = 0;
    tick_bit = 0;
    done_cyc = 0;
    do_start(SEED_A, 16'hFFFF);
    for (int c = 1; c <= 65600; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (bit_valid) nb++;
      if (max_tick) begin
        ticks++;
        tick_bit = bit_valid ? nb : -1;
      end
      tick();
    end
    n_cmp++;
    if (done_cyc !== 65537 || nb !== 65535) begin
      n_bad++;
      $display("FAIL period_done: got done_cycle=%0d bits=%0d required 65537/65535", done_cyc, nb);
    end
    n_cmp++;
    if (ticks !== 1 || tick_bit !== 65535) begin
      n_bad++;
      $display("FAIL period_max_tick: got count=%0d at bit %0d required 1 at 65535", ticks, tick_bit);
    end
    n_cmp++;
    if (num_ones !== 16'd32768 || num_zeroes !== 16'd32767) begin
      n_bad++;
      $display("FAIL period_counts: got ones=%0d zeroes=%0d required 32768/32767", num_ones, num_zeroes);
    end
    tick();
    $display("full_period: bits=%0d max_ticks=%0d ones=%0d zeroes=%0d", nb, ticks, num_ones, num_zeroes);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    seed    = '0;
    run_len = '0;
    @(negedge clk);
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_short_run();
    test_zero_seed();
    test_zero_len();
    test_abort(10, 1'b1, 10, 12, 1'b1, 4);
    test_abort(100, 1'b0, 100, 102, 1'b0, 0);
    test_abort_in_load();
    test_back_to_back();
    test_reset_mid_run();
    test_full_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_run_ctrl.md
# lfsr_run_ctrl

Run controller for the 16-bit Fibonacci LFSR bit generator. On request it seeds the LFSR, steps it for a programmed number of bits and streams the bits out with a valid strobe. It also counts ones and zeroes, flags each completed maximal period, and returns the statistics with a done pulse. It sits between a test/host sequencer and the LFSR datapath, replacing free-running operation with bounded, repeatable runs.

## Interface
- WIDTH, 16: LFSR width; taps fixed for 16 (x^16+x^14+x^13+x^11+1).
- CNT_W, 16: width of run_len and statistics counters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  request a run; sampled only in IDLE.
- abort  in  1  terminate a run early; sampled in LOAD/RUN.
- seed  in  WIDTH  initial LFSR state; captured on accepted start.
- run_len  in  CNT_W  number of bits to emit; captured on accepted start.
- busy  out  1  high in LOAD and RUN.
- bit_out  out  1  current LFSR output bit.
- bit_valid  out  1  bit_out is a fresh sequence bit.
- max_tick  out  1  one-cycle pulse: LFSR has returned to seed.
- num_ones  out  CNT_W  ones emitted this run.
- num_zeroes  out  CNT_W  zeroes emitted this run.
- done  out  1  one-cycle pulse: run finished, statistics final.
- aborted  out  1  qualifies done: run ended by abort; held until next LOAD.
- err_seed  out  1  one-cycle pulse: start rejected, seed == 0.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE with start=1:
  - seed==0: pulse err_seed next cycle, stay IDLE.
  - otherwise: capture seed/run_len, go to LOAD.
- LOAD, one cycle:
  - lfsr<=seed; clear num_ones, num_zeroes, bit counter, aborted.
  - run_len==0: go to DONE; otherwise go to RUN.
- RUN, each cycle:
  - bit_out=lfsr[0], bit_valid=1.
  - feedback f=lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5]; lfsr<={f,lfsr[15:1]}.
  - increment num_ones if bit_out else num_zeroes; both saturate at all-ones.
  - max_tick=1 in the same cycle if the next state equals the captured seed.
  - after run_len bits, go to DONE.
- DONE, one cycle: done=1, then IDLE.
- abort:
  - in RUN: stop after the current cycle's bit (which is counted), go to DONE with aborted=1.
  - in LOAD: go to DONE with zero counts and aborted=1.
- abort on the cycle the final bit is emitted: normal completion, aborted=0.
- start while busy or in DONE: ignored, not queued.
- num_ones/num_zeroes/aborted hold their values through IDLE until the next LOAD.
- Reset mid-run: immediate return to IDLE, all counts cleared, no done.

## Timing
- Reset values:
  - FSM=IDLE, lfsr=16'h0001.
  - busy, bit_out, bit_valid, max_tick, done, aborted, err_seed = 0.
  - num_ones, num_zeroes = 0.
- All outputs registered.
- Cycle numbering, start accepted at edge 0:
  - LOAD in cycle 1.
  - bit_valid in cycles 2..run_len+1.
  - done in cycle run_len+2.
- Start-to-done latency is run_len+2 cycles (2 when run_len==0).
- Earliest next start is accepted in the cycle after done, so there are no back-to-back LOADs.
- err_seed pulses in the cycle after the rejected start.
- Counts are final and stable when done is high.
- max_tick coincides with the bit_valid cycle of bit #65535, #131070, and so on.

## Structure
- Shared package lfsr_pkg:
  - LFSR_WIDTH=16, tap constant 16'hB400, state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3).
- Sub-module lfsr16_core (clk, reset, load, seed, step, state, bit_out) holds the shift register and feedback. The controller holds the FSM, counters and period compare.

## Test plan
- seed=16'hACE1, run_len=2, start → bits 1 then 0, state after step 1 = 16'h5670, num_ones=1, num_zeroes=1, done at cycle 4, aborted=0.
- seed=16'hACE1, run_len=65535 → exactly one max_tick, on the last bit; num_ones=32768, num_zeroes=32767.
- seed=0, start → err_seed pulse one cycle later, busy never rises, counts unchanged.
- run_len=0, seed=16'h0001 → LOAD then done at cycle 2, no bit_valid, counts 0.
- run_len=100, abort raised in the 10th bit_valid cycle → done with aborted=1, num_ones+num_zeroes=10.
  - Repeat with abort on the 100th bit → aborted=0, total=100.
- reset=0 during RUN (bit 50 of 100) → outputs return to reset values next cycle, no done.
  - A fresh start then reproduces the seed's sequence from bit 1.
